// File: rtl/display_scan_n.sv
// display_scan_n: multiplexed common-anode 7-segment scanner. It lights one digit at a time
//   and has a blanking gap, a per-digit enable mask with skipping, and a per-slot code snapshot.
// Latency: every output is registered. Outputs reflect the scan state one clock after the
//   inputs are sampled.
// Backpressure: none. The en input stalls the scan in place (cnt, idx and the snapshot hold)
//   and blanks the anodes while it is low.
// Ports:
//   clk, rst        - single clock; synchronous active-high reset
//   en              - scan enable (0 = freeze and blank)
//   digit_mask      - 1 = digit enabled; bit i drives anode_n[i]
//   digits_in       - packed 4-bit codes, digit i at [4*i+3:4*i]
//   anode_n         - active-low anode selects, at most one low
//   digit_out       - code snapshot for the current slot's digit
//   digit_idx       - index of the current slot's digit
//   slot_strobe     - one-cycle pulse on each slot boundary
module display_scan_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [3:0]              digit_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    slot_strobe
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  boundary;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [IDX_W-1:0]      idx_inc;
  logic [IDX_W-1:0]      search_idx;
  logic                  found;
  int                    cand;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  blank_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;

  assign boundary = (cnt == CNT_LAST);
  assign cnt_nxt  = boundary ? '0 : cnt + CNT_W'(1);
  assign idx_inc  = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

  // Find the next enabled digit after idx and wrap around. idx itself is tried last, so a
  // single enabled digit is picked again. With an empty mask the scan still steps by one
  // so the slot strobe and index keep moving.
  always_comb begin
    found      = 1'b0;
    search_idx = idx_inc;
    cand       = 0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      cand = (int'(idx) + k) % NUM_DIGITS;
      if (!found && digit_mask[cand]) begin
        found      = 1'b1;
        search_idx = IDX_W'(cand);
      end
    end
  end

  assign idx_nxt = boundary ? search_idx : idx;

  // The anode is chosen from the post-edge cnt/idx and the live mask. This holds each slot
  // dark for its first BLANK_CYCLES clocks. It also turns an anode off one clock after its
  // mask bit clears, even in the middle of a slot.
  assign blank_nxt = (BLANK_CYCLES != 0) && (int'(cnt_nxt) < BLANK_CYCLES);

  always_comb begin
    anode_nxt = '1;
    if (!blank_nxt && digit_mask[idx_nxt]) begin
      anode_nxt[idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= CNT_LAST;
      idx         <= IDX_LAST;
      anode_n     <= '1;
      digit_out   <= '0;
      slot_strobe <= 1'b0;
    end else if (!en) begin
      anode_n     <= '1;
      slot_strobe <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      anode_n     <= anode_nxt;
      slot_strobe <= boundary;
      // Capture the code only at the boundary. A mid-slot change to digits_in would
      // otherwise show up partway through a lit slot.
      if (boundary) begin
        digit_out <= digits_in[{idx_nxt, 2'b00} +: 4];
      end
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_display_scan_n.sv
// tb_display_scan_n: testbench for display_scan_n with a randomized and directed scoreboard.
// Latency: each expected entry covers the outputs one clock after its inputs are driven.
// Backpressure: not applicable; the monitor consumes one expected entry every cycle.
module tb_display_scan_n;

  localparam int N  = 4;
  localparam int CD = 8;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  digit_mask;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  anode_n;
  logic [3:0]    digit_out;
  logic [1:0]    digit_idx;
  logic          slot_strobe;

  display_scan_n #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (CD),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_mask (digit_mask),
    .digits_in  (digits_in),
    .anode_n    (anode_n),
    .digit_out  (digit_out),
    .digit_idx  (digit_idx),
    .slot_strobe(slot_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] an;
    logic [3:0]   dout;
    logic [1:0]   idx;
    logic         stb;
    logic         tmo;
    string        tag;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model. It tracks the position within the slot and the digit being shown.
  int           m_pos;
  int           m_cur;
  logic [N-1:0] m_anode;
  logic [3:0]   m_dout;
  logic         m_strobe;

  logic [N-1:0]   mask_v;
  logic [4*N-1:0] dig_v;

  // Return the smallest enabled digit above cur. If none is above cur, return the smallest
  // enabled digit overall, which may be cur itself. If no digit is enabled, return cur+1.
  function automatic int pick_next(input int cur, input logic [N-1:0] m);
    int lowest = -1;
    int above  = -1;
    for (int d = N - 1; d >= 0; d--) begin
      if (m[d]) begin
        lowest = d;
        if (d > cur) above = d;
      end
    end
    if (above >= 0) return above;
    if (lowest >= 0) return lowest;
    return (cur + 1) % N;
  endfunction

  task automatic model_edge(input logic r, input logic e);
    if (r) begin
      m_pos = CD - 1; m_cur = N - 1; m_anode = '1; m_dout = 4'h0; m_strobe = 1'b0;
    end else if (!e) begin
      m_anode = '1; m_strobe = 1'b0;
    end else begin
      if (m_pos == CD - 1) begin
        m_pos    = 0;
        m_cur    = pick_next(m_cur, mask_v);
        m_dout   = dig_v[4*m_cur +: 4];
        m_strobe = 1'b1;
      end else begin
        m_pos    = m_pos + 1;
        m_strobe = 1'b0;
      end
      if (m_pos < BL || !mask_v[m_cur]) m_anode = '1;
      else m_anode = ~(4'b0001 << m_cur);
    end
  endtask

  string phase = "init";

  // Drive one cycle's inputs just after the negedge, then queue the outputs expected
  // after the following posedge.
  task automatic cyc(input logic r, input logic e);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; en = e; digit_mask = mask_v; digits_in = dig_v;
    model_edge(r, e);
    x.an = m_anode; x.dout = m_dout; x.idx = 2'(m_cur); x.stb = m_strobe;
    x.tmo = 1'b0; x.tag = phase;
    q.push_back(x);
  endtask

  task automatic run_until(input int pos, input int dig, input int cap);
    int n = 0;
    exp_t x;
    while (!(m_pos == pos && (dig < 0 || m_cur == dig))) begin
      if (n == cap) begin
        x.an = '1; x.dout = '0; x.idx = '0; x.stb = 1'b0; x.tmo = 1'b1; x.tag = phase;
        q.push_back(x);
        return;
      end
      cyc(1'b0, 1'b1);
      n++;
    end
  endtask

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s actual=%0h expected=%0h t=%0t", tag, name, act, exp, $time);
    end
  endtask

  // Monitor: at each negedge, compare the DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].tmo) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s/wait_timeout actual=expired required=reached", e.tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, "anode_n", 32'(anode_n), 32'(e.an));
      chk(e.tag, "digit_out", 32'(digit_out), 32'(e.dout));
      chk(e.tag, "digit_idx", 32'(digit_idx), 32'(e.idx));
      chk(e.tag, "slot_strobe", 32'(slot_strobe), 32'(e.stb));
      checks++;
      if ($countones(~anode_n) > 1) begin
        failures++;
        $display("FAIL %s/anode_onehot actual=%b required=at_most_one_low", e.tag, anode_n);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mask_v = 4'b1111; dig_v = 16'h4321;
    digit_mask = mask_v; digits_in = dig_v;
    m_pos = CD - 1; m_cur = N - 1; m_anode = '1; m_dout = '0; m_strobe = 1'b0;

    phase = "reset";
    repeat (2) cyc(1'b1, 1'b1);

    phase = "scan";
    repeat (40) cyc(1'b0, 1'b1);

    phase = "skip";
    mask_v = 4'b0101;
    repeat (32) cyc(1'b0, 1'b1);

    phase = "mask0";
    mask_v = 4'b0000;
    repeat (32) cyc(1'b0, 1'b1);

    phase = "freeze";
    mask_v = 4'b1111;
    run_until(4, -1, 64);
    repeat (5) cyc(1'b0, 1'b0);
    repeat (12) cyc(1'b0, 1'b1);

    phase = "tear";
    run_until(3, 1, 64);
    dig_v = 16'h9999;
    repeat (16) cyc(1'b0, 1'b1);

    phase = "midrst";
    dig_v = 16'h4321;
    run_until(5, -1, 64);
    cyc(1'b1, 1'b1);
    repeat (12) cyc(1'b0, 1'b1);
    run_until(5, -1, 64);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b1);

    phase = "maskmid";
    run_until(4, -1, 64);
    mask_v[m_cur] = 1'b0;
    repeat (10) cyc(1'b0, 1'b1);

    phase = "single";
    mask_v = 4'b1000;
    repeat (24) cyc(1'b0, 1'b1);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) mask_v = 4'($urandom);
      if ($urandom_range(0, 24) == 0) dig_v = 16'($urandom);
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0));
    end

    repeat (3) @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
